// File: rtl/mioc_gate_pkg.sv
// Shared definitions for MIOC gate-characterization cells.
//   CNT_W_DEF : default width of pattern/error counters
//   cov_idx_t : 2-bit coverage index {in1,in2}
//   XNOR2_TT  : XNOR2 truth table indexed by {in1,in2}
package mioc_gate_pkg;

   localparam int unsigned CNT_W_DEF = 16;

   typedef logic [1:0] cov_idx_t;

   localparam logic [3:0] XNOR2_TT = 4'b1001;

   // Behavioural reference taken from the truth table, independent of any gate network
   function automatic logic xnor2_ref(input cov_idx_t idx);
      return XNOR2_TT[idx];
   endfunction

endpackage

// File: rtl/mioc_xnor2_nmos_cell_if.sv
// Harness-side bundle for the XNOR2 characterization cell.
//   master : gate-test harness (drives in1/in2/sample, observes results)
//   slave  : the cell wrapper
interface mioc_xnor2_nmos_cell_if
   import mioc_gate_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) ();

   logic             in1;
   logic             in2;
   logic             sample;
   logic             z;
   logic             z_q;
   logic [CNT_W-1:0] pat_cnt;
   logic [3:0]       cov;
   logic             cov_done;
   logic             err;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output in1, in2, sample,
      input  z, z_q, pat_cnt, cov, cov_done, err, err_cnt
   );

   modport slave (
      input  in1, in2, sample,
      output z, z_q, pat_cnt, cov, cov_done, err, err_cnt
   );

endinterface

// File: rtl/mioc_nmos_pd_net.sv
// NMOS-style XNOR2 core: two series pull-down paths and a resistive pull-up.
//   a, b : gate inputs
//   z_c  : combinational output, high unless a pull-down path conducts
module mioc_nmos_pd_net (
   input  logic a,
   input  logic b,
   output logic z_c
);

   logic pd1;
   logic pd2;

   // Each path conducts when exactly one input is high
   assign pd1 = a & ~b;
   assign pd2 = ~a & b;

   assign z_c = ~(pd1 | pd2);

endmodule

// File: rtl/mioc_xnor2_nmos_cell.sv
// XNOR2 characterization cell: NMOS gate core plus clocked observation wrapper.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : in1/in2/sample in; z (comb), z_q, pat_cnt, cov, cov_done (comb),
//          err, err_cnt out
module mioc_xnor2_nmos_cell
   import mioc_gate_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input logic                     clk,
   input logic                     rst,
   mioc_xnor2_nmos_cell_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             z_net;
   cov_idx_t         idx_c;
   logic             ref_c;
   logic             smp_c;
   logic             mism_c;

   logic             z_q_r;
   logic [CNT_W-1:0] pat_cnt_r;
   logic [3:0]       cov_r;
   logic             err_r;
   logic [CNT_W-1:0] err_cnt_r;

   // Swappable gate core
   mioc_nmos_pd_net u_pd_net (
      .a   (bus.in1),
      .b   (bus.in2),
      .z_c (z_net)
   );

   assign idx_c  = {bus.in1, bus.in2};
   assign ref_c  = xnor2_ref(idx_c);
   assign mism_c = z_net ^ ref_c;

   // Reduces to sample in hardware; in 4-state simulation an X/Z input makes
   // the term X, so the if() below treats that strobe as no sample.
   assign smp_c  = bus.sample & ((bus.in1 ^ bus.in2) | ~(bus.in1 ^ bus.in2));

   // Observation registers, counters, coverage and checker
   always_ff @(posedge clk) begin
      if (rst) begin
         z_q_r     <= 1'b1;
         pat_cnt_r <= '0;
         cov_r     <= '0;
         err_r     <= 1'b0;
         err_cnt_r <= '0;
      end else begin
         z_q_r <= z_net;
         if (smp_c) begin
            if (pat_cnt_r != CNT_MAX) begin
               pat_cnt_r <= pat_cnt_r + CNT_W'(1);
            end
            cov_r[idx_c] <= 1'b1;
            if (mism_c) begin
               err_r <= 1'b1;
               if (err_cnt_r != CNT_MAX) begin
                  err_cnt_r <= err_cnt_r + CNT_W'(1);
               end
            end
         end
      end
   end

   assign bus.z        = z_net;
   assign bus.z_q      = z_q_r;
   assign bus.pat_cnt  = pat_cnt_r;
   assign bus.cov      = cov_r;
   assign bus.cov_done = &cov_r;
   assign bus.err      = err_r;
   assign bus.err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_mioc_xnor2_nmos_cell.sv
// Scoreboard bench for mioc_xnor2_nmos_cell: main instance (CNT_W=16) and a
// narrow instance (CNT_W=2) for counter saturation.
module tb_mioc_xnor2_nmos_cell;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mioc_xnor2_nmos_cell_if #(.CNT_W(16)) m ();
   mioc_xnor2_nmos_cell_if #(.CNT_W(2))  s2 ();

   mioc_xnor2_nmos_cell #(.CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (m.slave)
   );

   mioc_xnor2_nmos_cell #(.CNT_W(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (s2.slave)
   );

   typedef struct packed {
      logic        z_q;
      logic [15:0] pat;
      logic [3:0]  cov;
      logic        err;
      logic [15:0] ecnt;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] sat_q[$];

   int vectors     = 0;
   int miscompares = 0;

   // Bench-side model state
   logic        mz_q  = 1'b1;
   logic [15:0] mpat  = '0;
   logic [3:0]  mcov  = '0;
   logic        merr  = 1'b0;
   logic [15:0] mecnt = '0;
   logic        force_on = 1'b0;

   // Drive one clock of stimulus, push the expected post-edge state, sample #1 after the edge
   task automatic cycle(input logic a, input logic b, input logic s, input logic r);
      logic zn;
      logic [1:0] ix;
      @(negedge clk);
      m.in1 = a; m.in2 = b; m.sample = s; rst = r;
      ix = {a, b};
      if (r) begin
         mz_q = 1'b1; mpat = '0; mcov = '0; merr = 1'b0; mecnt = '0;
      end else begin
         zn   = force_on ? 1'b1 : (a == b);
         mz_q = zn;
         if (s) begin
            if (mpat != 16'hFFFF) mpat = mpat + 16'd1;
            mcov[ix] = 1'b1;
            if (zn != (a == b)) begin
               merr = 1'b1;
               if (mecnt != 16'hFFFF) mecnt = mecnt + 16'd1;
            end
         end
      end
      sb.push_back('{mz_q, mpat, mcov, merr, mecnt});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
         e = sb.pop_front();
         vectors++;
         if ({m.z_q, m.pat_cnt, m.cov, m.err, m.err_cnt} !== e) begin
            miscompares++;
            $display("FAIL reset_state act=%h req=%h", {m.z_q, m.pat_cnt, m.cov, m.err, m.err_cnt}, e);
         end
      end
      vectors++;
      if (m.cov_done !== 1'b0 || m.z !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_comb cov_done=%b z=%b req cov_done=0 z=1", m.cov_done, m.z);
      end
   endtask

   task automatic test_sweep();
      exp_t e;
      logic [3:0] ztab = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         cycle(i[1], i[0], 1'b1, 1'b0);
         e = sb.pop_front();
         vectors++;
         if (m.z !== ztab[i]) begin
            miscompares++;
            $display("FAIL sweep_z pat=%0d act=%b req=%b", i, m.z, ztab[i]);
         end
         vectors++;
         if ({m.z_q, m.pat_cnt, m.cov, m.err, m.err_cnt} !== e) begin
            miscompares++;
            $display("FAIL sweep_state pat=%0d act=%h req=%h", i, {m.z_q, m.pat_cnt, m.cov, m.err, m.err_cnt}, e);
         end
      end
      vectors++;
      if (m.pat_cnt !== 16'd4 || m.cov !== 4'b1111 || m.cov_done !== 1'b1 || m.err !== 1'b0) begin
         miscompares++;
         $display("FAIL sweep_end pat=%0d cov=%b done=%b err=%b req 4/1111/1/0", m.pat_cnt, m.cov, m.cov_done, m.err);
      end
   endtask

   task automatic test_registered();
      exp_t e;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      vectors++;
      if (m.z_q !== e.z_q) begin
         miscompares++;
         $display("FAIL reg_pre z_q=%b req=%b", m.z_q, e.z_q);
      end
      @(negedge clk);
      m.in2 = 1'b1;
      #1;
      vectors++;
      if (m.z !== 1'b0 || m.z_q !== 1'b1) begin
         miscompares++;
         $display("FAIL reg_imm z=%b z_q=%b req z=0 z_q=1", m.z, m.z_q);
      end
      @(posedge clk);
      #1;
      mz_q = 1'b0;
      vectors++;
      if (m.z_q !== 1'b0) begin
         miscompares++;
         $display("FAIL reg_late z_q=%b req=0", m.z_q);
      end
   endtask

   task automatic test_reset_priority();
      exp_t e;
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      e = sb.pop_front();
      vectors++;
      if ({m.z_q, m.pat_cnt, m.cov, m.err, m.err_cnt} !== e || m.pat_cnt !== 16'd0 || m.cov !== 4'b0000) begin
         miscompares++;
         $display("FAIL rst_prio pat=%0d cov=%b req pat=0 cov=0000", m.pat_cnt, m.cov);
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      void'(sb.pop_front());
   endtask

   task automatic test_saturation();
      logic [1:0] cnt = 2'd0;
      logic [1:0] req;
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      void'(sb.pop_front());
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         rst = 1'b0;
         s2.in1 = k[0]; s2.in2 = k[1]; s2.sample = 1'b1;
         if (cnt != 2'd3) cnt = cnt + 2'd1;
         sat_q.push_back(cnt);
         @(posedge clk);
         #1;
         req = sat_q.pop_front();
         vectors++;
         if (s2.pat_cnt !== req) begin
            miscompares++;
            $display("FAIL sat_cnt sample=%0d act=%0d req=%0d", k, s2.pat_cnt, req);
         end
      end
      @(negedge clk);
      s2.sample = 1'b0;
      vectors++;
      if (s2.err !== 1'b0 || s2.cov !== 4'b1111) begin
         miscompares++;
         $display("FAIL sat_side err=%b cov=%b req err=0 cov=1111", s2.err, s2.cov);
      end
   endtask

   task automatic test_fault();
      exp_t e;
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      void'(sb.pop_front());
      force dut.z_net = 1'b1;
      force_on = 1'b1;
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      e = sb.pop_front();
      vectors++;
      if ({m.z_q, m.pat_cnt, m.cov, m.err, m.err_cnt} !== e || m.err !== 1'b1 || m.err_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL fault_hit err=%b err_cnt=%0d req err=1 err_cnt=1", m.err, m.err_cnt);
      end
      release dut.z_net;
      force_on = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cycle(1'b1, 1'b1, k[0], 1'b0);
         e = sb.pop_front();
         vectors++;
         if ({m.z_q, m.pat_cnt, m.cov, m.err, m.err_cnt} !== e || m.err !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_sticky act=%h req=%h", {m.z_q, m.pat_cnt, m.cov, m.err, m.err_cnt}, e);
         end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      e = sb.pop_front();
      vectors++;
      if (m.err !== 1'b0 || m.err_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL fault_clear err=%b err_cnt=%0d req 0/0", m.err, m.err_cnt);
      end
   endtask

   initial begin
      m.in1 = 1'b0; m.in2 = 1'b0; m.sample = 1'b0;
      s2.in1 = 1'b0; s2.in2 = 1'b0; s2.sample = 1'b0;
      test_reset();
      test_sweep();
      test_registered();
      test_reset_priority();
      test_saturation();
      test_fault();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
